// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: a valid/ready stage with a two-entry skid buffer,
// synchronous flush, occupancy reporting and a saturating back-pressure counter.
module pipe_stage_elastic #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  // Encodings double as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           stateQ, stateD;
  logic [WIDTH-1:0] mainQ, skidQ;
  logic             inFire, outFire;
  logic             loadMainIn, loadMainSkid, loadSkid;

  // Handshake outputs decode the state register only, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (stateQ != TWO);
  assign out_valid = (stateQ != EMPTY);
  assign occupancy = stateQ;
  assign out_data  = mainQ;

  assign inFire  = in_valid & in_ready;
  assign outFire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= EMPTY;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD       = stateQ;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    case (stateQ)
      EMPTY: if (inFire) begin
        stateD     = ONE;
        loadMainIn = 1'b1;
      end
      ONE: begin
        if (inFire && outFire) begin
          loadMainIn = 1'b1;
        end else if (inFire) begin
          stateD   = TWO;
          loadSkid = 1'b1;
        end else if (outFire) begin
          stateD = EMPTY;
        end
      end
      TWO: if (outFire) begin
        stateD       = ONE;
        loadMainSkid = 1'b1;
      end
      default: stateD = EMPTY;
    endcase
    // Flush kills everything held plus any word arriving this edge.
    if (flush) begin
      stateD       = EMPTY;
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainQ <= '0;
      skidQ <= '0;
    end else begin
      if (loadMainIn)        mainQ <= in_data;
      else if (loadMainSkid) mainQ <= skidQ;
      if (loadSkid)          skidQ <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          stall_cnt <= '0;
    else if (stall_clr)                                  stall_cnt <= '0;
    else if (out_valid && !out_ready && !flush &&
             stall_cnt != CNT_MAX)                       stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and randomized checks of pipe_stage_elastic against hand values and a queue model.
module tb_pipe_stage_elastic;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, out_ready, stall_clr;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] in_data, out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int nChecks = 0;
  int nFail   = 0;

  pipe_stage_elastic #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] q[$];

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    stall_clr = 1'b0; in_data = '0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_occ",       {30'd0, occupancy}, 32'd0);
    chk("rst_stall",     {28'd0, stall_cnt}, 32'd0);
    chk("rst_out_data",  out_data,           32'd0);
    rst_n = 1'b1;
    step();

    // Streaming at full throughput
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = i;
      step();
      chk("stream_data",  out_data,           i);
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_occ",   {30'd0, occupancy}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_occ", {30'd0, occupancy}, 32'd0);
    chk("stream_stall",     {28'd0, stall_cnt}, 32'd0);

    // Backpressure fill then drain
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step();
    chk("bp_occ1",  {30'd0, occupancy}, 32'd1);
    chk("bp_data1", out_data,           32'hA);
    chk("bp_stall0", {28'd0, stall_cnt}, 32'd0);
    in_data = 32'hB;
    step();
    chk("bp_occ2",   {30'd0, occupancy}, 32'd2);
    chk("bp_inrdy0", {31'd0, in_ready},  32'd0);
    chk("bp_stall1", {28'd0, stall_cnt}, 32'd1);
    chk("bp_hold",   out_data,           32'hA);
    in_valid = 1'b0;
    step();
    chk("bp_stall2", {28'd0, stall_cnt}, 32'd2);
    chk("bp_hold2",  out_data,           32'hA);
    out_ready = 1'b1;
    step();
    chk("bp_drain_b",   out_data,           32'hB);
    chk("bp_drain_occ", {30'd0, occupancy}, 32'd1);
    chk("bp_inrdy1",    {31'd0, in_ready},  32'd1);
    step();
    chk("bp_empty_occ",   {30'd0, occupancy}, 32'd0);
    chk("bp_empty_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_stall_keep",  {28'd0, stall_cnt}, 32'd2);
    out_ready = 1'b0; stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("clr", {28'd0, stall_cnt}, 32'd0);

    // Flush with two entries and a concurrent incoming word
    in_valid = 1'b1; in_data = 32'h1;
    step();
    in_data = 32'h2;
    step();
    chk("fl_occ2", {30'd0, occupancy}, 32'd2);
    flush = 1'b1; in_data = 32'hC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_occ",   {30'd0, occupancy}, 32'd0);
    chk("fl_inrdy", {31'd0, in_ready},  32'd1);
    chk("fl_stall", {28'd0, stall_cnt}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_no_c", {31'd0, out_valid}, 32'd0);
    end

    // Counter saturation and clear under persistent stall
    out_ready = 1'b0; stall_clr = 1'b1; in_valid = 1'b1; in_data = 32'h77;
    step();
    stall_clr = 1'b0; in_valid = 1'b0;
    chk("sat_start", {28'd0, stall_cnt}, 32'd0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_max", {28'd0, stall_cnt}, 32'd15);
    step();
    chk("sat_hold", {28'd0, stall_cnt}, 32'd15);
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("sat_clr", {28'd0, stall_cnt}, 32'd0);
    step();
    chk("sat_resume", {28'd0, stall_cnt}, 32'd1);

    // Asynchronous reset between edges
    in_valid = 1'b1; in_data = 32'h78;
    step();
    in_valid = 1'b0;
    chk("ar_occ2", {30'd0, occupancy}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_occ",   {30'd0, occupancy}, 32'd0);
    chk("ar_stall", {28'd0, stall_cnt}, 32'd0);
    chk("ar_inrdy", {31'd0, in_ready},  32'd1);
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ar_first",  out_data,           32'h55);
    chk("ar_first_v", {31'd0, out_valid}, 32'd1);
    step();
    chk("ar_drained", {30'd0, occupancy}, 32'd0);

    // Random soak against a queue model
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bit mIn, mOut;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = $urandom;
      chk("soak_occ",   {30'd0, occupancy}, q.size());
      chk("soak_valid", {31'd0, out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
      chk("soak_inrdy", {31'd0, in_ready},  (q.size() < 2)  ? 32'd1 : 32'd0);
      if (q.size() != 0) chk("soak_data", out_data, q[0]);
      mIn  = in_valid && (q.size() < 2);
      mOut = out_ready && (q.size() != 0);
      if (flush) q.delete();
      else begin
        if (mOut) void'(q.pop_front());
        if (mIn)  q.push_back(in_data);
      end
      step();
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed MEM/WB pipeline register.
- Generic WIDTH-bit stage with valid/ready handshake, a two-entry skid buffer, synchronous flush, occupancy output and a saturating back-pressure counter.
- Lets any pipeline boundary (IF/ID, EX/MEM, MEM/WB) stall or kill cleanly without combinational ready paths crossing the stage.
- Sits between two pipeline stages; the upstream side sees a registered in_ready.

Parameters:
- WIDTH, 32: payload width in bits (callers concatenate funct3, addresses, wb_sel, rd, etc.).
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream has payload.
- in_ready  output  1  stage can accept; registered, depends only on state.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream payload valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  payload; driven from main register only.
- occupancy  output  2  entries held (0..2).
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- stall_clr  input  1  synchronous clear of stall_cnt.

Behaviour:
- Reset is asynchronous, active-low: rst_n=0 forces state EMPTY, main and skid data 0, out_valid=0, in_ready=1, occupancy=0, stall_cnt=0.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States are EMPTY (occ 0), ONE (main valid, occ 1) and TWO (main+skid valid, occ 2).
- in_ready = (state != TWO); out_valid = (state != EMPTY).
- EMPTY:
  - in_fire -> ONE, main <= in_data.
- ONE:
  - in_fire & out_fire -> ONE, main <= in_data (full throughput).
  - in_fire & !out_fire -> TWO, skid <= in_data.
  - !in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- TWO:
  - No in_fire is possible.
  - out_fire -> ONE, main <= skid.
  - Otherwise hold.
- Latency: in_data accepted at edge N appears on out_data after edge N when the stage was EMPTY, or behind older entries otherwise. Order is strictly FIFO.
- Data registers update only on the transitions listed. out_data is stable while out_valid=1 and out_ready=0.
- flush=1 at an edge: next state EMPTY and occupancy 0, regardless of in_valid/out_ready. A concurrent in_fire is discarded. A concurrent out_fire still counts as consumed downstream. Data registers may hold stale values; out_valid=0 masks them.
- stall_cnt:
  - Increments by 1 on each edge where out_valid & !out_ready and flush=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - stall_clr has priority over increment and sets it to 0.
- Reset asserted mid-transfer: all entries are lost and outputs go to reset values immediately, without waiting for clk.
- No combinational path from out_ready to in_ready.

Test Plan:
- Streaming: WIDTH=32, out_ready=1, in_valid=1 with data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 on 8 consecutive cycles, each one cycle after its acceptance; occupancy stays 1; stall_cnt=0.
- Backpressure fill: send 0xA, 0xB with out_ready=0 -> occupancy 1 then 2; in_ready=0 after the second edge; stall_cnt counts up. Then raise out_ready for 2 cycles -> 0xA then 0xB appear, occupancy 2->1->0, in_ready returns to 1 after the first drain.
- Flush with entries: occupancy=2, assert flush together with in_valid=1 carrying 0xC -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xC is never output.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays there. Pulse stall_clr -> 0 the next cycle, even though the stall persists.
- Async reset mid-operation: occupancy=2, drop rst_n between clock edges -> out_valid, occupancy and stall_cnt go to 0 before the next edge. Release rst_n -> the first accepted word 0x55 appears one cycle later.
- Random soak: random in_valid/out_ready/flush over 10k cycles against a queue model -> no loss, duplication or reordering outside flushes; occupancy never exceeds 2.
